nubus_slave_resp: RTL and testbench
===================================

NUBUS_SLAVE_RESP -- requirements
Module: nubus_slave_resp

Interface
REQ-001 Parameter SLOT_ID, default 4'h9: card slot number; decoded standard slot space is ~nub_adn[31:24] == {4'hF, SLOT_ID}.
REQ-002 Parameter TIMEOUT_CYC, default 255: max cycles waiting for mem_ready before a timeout response; counter is 8 bits.
REQ-003 nub_clkn  input  1  NuBus clock; all state updates on its rising edge.
REQ-004 nub_reset  input  1  asynchronous, active-high reset.
REQ-005 nub_startn  input  1  sampled START*, active low.
REQ-006 nub_ackn  input  1  sampled ACK*, active low; START* and ACK* both low marks an attention cycle.
REQ-007 nub_tm1n, nub_tm0n  input  1 each  sampled transfer mode, active low.
REQ-008 nub_adn  input  32  sampled AD bus, active low.
REQ-009 slv_ackcyn  output  1  low for exactly one cycle: slave ACK cycle, consumed by the bus driver.
REQ-010 slv_errorn  output  2  response status for the driver TM lines; 2'b11 complete, 2'b10 error, 2'b01 timeout.
REQ-011 slv_adoe  output  1  high during a read ACK cycle: enable slv_rdatan onto AD.
REQ-012 slv_rdatan  output  32  read data, active low (~mem_rdata, registered).
REQ-013 mem_valid  output  1  local request strobe.
REQ-014 mem_write  output  1  1 = write.
REQ-015 mem_addr  output  32  true-polarity address.
REQ-016 mem_wdata  output  32  true-polarity write data.
REQ-017 mem_wstrb  output  4  byte enables.
REQ-018 mem_ready  input  1  local completion, one-cycle pulse.
REQ-019 mem_rdata  input  32  read data, valid with mem_ready.
REQ-020 mem_err  input  1  local error, valid with mem_ready.

Function
REQ-021 FSM states: IDLE, WDATA, WAIT, ACK.
REQ-022 IDLE -> (WDATA if write, else WAIT) when nub_startn=0, nub_ackn=1 and the slot address matches; otherwise stay in IDLE.
REQ-023 Attention cycles (START* and ACK* both low) are ignored in every state.
REQ-024 On accept: mem_addr <= ~nub_adn; mem_write <= ~nub_tm1n.
REQ-025 Byte enables: nub_tm0n=1 gives mem_wstrb=4'b1111; nub_tm0n=0 sets only bit (~nub_adn[1:0]).
REQ-026 WDATA lasts exactly one cycle: mem_wdata <= ~nub_adn, then go to WAIT.
REQ-027 WAIT: mem_valid=1 and the counter increments each cycle; mem_valid is 0 in all other states.
REQ-028 WAIT exit on mem_ready: status 2'b11 (or 2'b10 if mem_err); latch slv_rdatan <= ~mem_rdata on reads; go to ACK.
REQ-029 WAIT exit on counter reaching TIMEOUT_CYC with no mem_ready: status 2'b01; go to ACK.
REQ-030 If mem_ready and timeout occur in the same cycle, mem_ready wins.
REQ-031 ACK: slv_ackcyn=0 and slv_errorn=latched status; slv_adoe=1 only for reads with status 11; next state IDLE.
REQ-032 Latency: read ACK cycle is one cycle after mem_ready; write ACK cycle is one cycle after mem_ready.
REQ-033 A new START* in the ACK cycle is not accepted; it is evaluated again only from IDLE.
REQ-034 In IDLE, ACK and WDATA: slv_ackcyn=1, slv_errorn=2'b11, slv_adoe=0; slv_errorn=2'b11 also in WAIT.

Reset
REQ-035 nub_reset forces IDLE and counter=0, including mid-transaction with no ACK issued.
REQ-036 Reset values: slv_ackcyn=1, slv_errorn=2'b11, slv_adoe=0, slv_rdatan=32'hFFFFFFFF.
REQ-037 Reset values: mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
REQ-038 The first accept after reset release can occur on the first clock edge.

Structure
REQ-039 Shared package nubus_pkg holds the FSM state enum, the status constants (NUB_ST_OK, NUB_ST_ERR, NUB_ST_TMO) and the slot-space prefix 4'hF.
REQ-040 Single flat module; no sub-modules.

Verification
REQ-041 Read test: SLOT_ID=9, START with nub_adn=~32'hF9000010, tm1n=1, tm0n=1; mem_ready after 3 cycles with rdata=32'hDEADBEEF.
  Required: mem_addr=32'hF9000010; one ACK cycle with slv_errorn=11, slv_adoe=1 and slv_rdatan=32'h21524110.
REQ-042 Byte write test: address F9000002, tm1n=0, tm0n=0, next-cycle data ~32'h000000AB.
  Required: mem_wstrb=4'b0100, mem_wdata=32'h000000AB, one ACK cycle with status 11.
REQ-043 Timeout test: mem_ready never asserted.
  Required: ACK exactly TIMEOUT_CYC cycles after WAIT entry, with slv_errorn=01 and slv_adoe=0.
REQ-044 Decode test: START to slot A (F9 vs FA), and an attention cycle (START and ACK both low).
  Required: mem_valid and slv_ackcyn never asserted.
REQ-045 Reset test: nub_reset pulsed during WAIT.
  Required: outputs return to reset values immediately (asynchronously); the next valid START is accepted normally.
REQ-046 Error test: mem_ready and mem_err asserted in the same cycle the timeout count is reached.
  Required: status 10 (mem_ready wins over timeout).

Source files
------------

// File: rtl/nubus_pkg.sv
// Shared NuBus slave definitions: FSM state encoding, response status codes
// (as driven onto the active-low TM lines) and the standard slot-space prefix.
package nubus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } nub_state_e;

    localparam logic [1:0] NUB_ST_OK  = 2'b11;
    localparam logic [1:0] NUB_ST_ERR = 2'b10;
    localparam logic [1:0] NUB_ST_TMO = 2'b01;

    localparam logic [3:0] NUB_SLOT_PREFIX = 4'hF;

endpackage

// File: rtl/nubus_slave_resp.sv
// NuBus slave responder: decodes standard slot space, turns a NuBus transaction
// into a local memory request, and produces the one-cycle slave ACK with status.
module nubus_slave_resp
    import nubus_pkg::*;
#(
    parameter logic [3:0] SLOT_ID     = 4'h9,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic        nub_clkn,
    input  logic        nub_reset,
    input  logic        nub_startn,
    input  logic        nub_ackn,
    input  logic        nub_tm1n,
    input  logic        nub_tm0n,
    input  logic [31:0] nub_adn,
    output logic        slv_ackcyn,
    output logic [1:0]  slv_errorn,
    output logic        slv_adoe,
    output logic [31:0] slv_rdatan,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    // Last counter value in WAIT; the following edge without mem_ready times out,
    // so the ACK lands exactly TIMEOUT_CYC cycles after WAIT entry.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    nub_state_e  state_q;
    logic [7:0]  cnt_q;
    logic [31:0] ad_true;
    logic        slot_hit;
    logic        start_cyc;

    assign ad_true   = ~nub_adn;
    assign slot_hit  = (ad_true[31:24] == {NUB_SLOT_PREFIX, SLOT_ID});
    // START* with ACK* low is an attention cycle, never a transaction start.
    assign start_cyc = !nub_startn && nub_ackn;

    // Transaction FSM with all bus and memory-side outputs registered.
    always_ff @(posedge nub_clkn or posedge nub_reset) begin
        if (nub_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            slv_ackcyn <= 1'b1;
            slv_errorn <= NUB_ST_OK;
            slv_adoe   <= 1'b0;
            slv_rdatan <= 32'hFFFF_FFFF;
            mem_valid  <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_cyc && slot_hit) begin
                        mem_addr  <= ad_true;
                        mem_write <= ~nub_tm1n;
                        mem_wstrb <= nub_tm0n ? 4'b1111 : (4'b0001 << ad_true[1:0]);
                        cnt_q     <= '0;
                        if (!nub_tm1n) begin
                            state_q <= ST_WDATA;
                        end else begin
                            state_q   <= ST_WAIT;
                            mem_valid <= 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    mem_wdata <= ad_true;
                    mem_valid <= 1'b1;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        // A completion in the timeout cycle still counts as a completion.
                        mem_valid  <= 1'b0;
                        slv_ackcyn <= 1'b0;
                        slv_errorn <= mem_err ? NUB_ST_ERR : NUB_ST_OK;
                        slv_adoe   <= !mem_write && !mem_err;
                        if (!mem_write) begin
                            slv_rdatan <= ~mem_rdata;
                        end
                        state_q <= ST_ACK;
                    end else if (cnt_q == TMO_LAST) begin
                        mem_valid  <= 1'b0;
                        slv_ackcyn <= 1'b0;
                        slv_errorn <= NUB_ST_TMO;
                        slv_adoe   <= 1'b0;
                        state_q    <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_ACK: begin
                    // A START seen here is deliberately dropped; it is re-evaluated from IDLE.
                    slv_ackcyn <= 1'b1;
                    slv_errorn <= NUB_ST_OK;
                    slv_adoe   <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nubus_slave_resp.sv
// Directed bench for nubus_slave_resp: inputs are driven on the falling clock
// edge and outputs are sampled on the falling edge after the DUT's rising edge.
module tb_nubus_slave_resp;

    localparam int TMO = 255;

    logic        nub_clkn = 1'b0;
    logic        nub_reset = 1'b0;
    logic        nub_startn = 1'b1;
    logic        nub_ackn = 1'b1;
    logic        nub_tm1n = 1'b1;
    logic        nub_tm0n = 1'b1;
    logic [31:0] nub_adn = 32'hFFFF_FFFF;
    logic        slv_ackcyn;
    logic [1:0]  slv_errorn;
    logic        slv_adoe;
    logic [31:0] slv_rdatan;
    logic        mem_valid;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_err = 1'b0;

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    bit valid_seen = 0;

    nubus_slave_resp #(.SLOT_ID(4'h9), .TIMEOUT_CYC(TMO)) dut (
        .nub_clkn(nub_clkn), .nub_reset(nub_reset), .nub_startn(nub_startn),
        .nub_ackn(nub_ackn), .nub_tm1n(nub_tm1n), .nub_tm0n(nub_tm0n),
        .nub_adn(nub_adn), .slv_ackcyn(slv_ackcyn), .slv_errorn(slv_errorn),
        .slv_adoe(slv_adoe), .slv_rdatan(slv_rdatan), .mem_valid(mem_valid),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_err(mem_err)
    );

    always #5 nub_clkn = ~nub_clkn;

    always @(negedge nub_clkn) begin
        if (slv_ackcyn === 1'b0) ack_cnt++;
        if (mem_valid === 1'b1) valid_seen = 1;
    end

    task automatic idle_bus();
        nub_startn = 1'b1; nub_ackn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1;
        nub_adn = 32'hFFFF_FFFF;
    endtask

    task automatic drive_start(input logic [31:0] addr, input logic tm1n, input logic tm0n);
        nub_startn = 1'b0; nub_ackn = 1'b1; nub_tm1n = tm1n; nub_tm0n = tm0n;
        nub_adn = ~addr;
    endtask

    task automatic test_reset();
        #1 nub_reset = 1'b1;
        @(negedge nub_clkn);
        total++; if (slv_ackcyn !== 1'b1) begin bad++; $display("FAIL rst_ackcyn: got %b want 1", slv_ackcyn); end
        total++; if (slv_errorn !== 2'b11) begin bad++; $display("FAIL rst_errorn: got %b want 11", slv_errorn); end
        total++; if (slv_adoe !== 1'b0) begin bad++; $display("FAIL rst_adoe: got %b want 0", slv_adoe); end
        total++; if (slv_rdatan !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_rdatan: got %h want ffffffff", slv_rdatan); end
        total++; if (mem_valid !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL rst_mem_ctl: got valid=%b write=%b want 0 0", mem_valid, mem_write); end
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin bad++; $display("FAIL rst_mem_data: got addr=%h wdata=%h wstrb=%b want zeros", mem_addr, mem_wdata, mem_wstrb); end
        // Release reset with START already present: first edge must accept.
        nub_reset = 1'b0;
        drive_start(32'hF900_0040, 1'b1, 1'b1);
        @(negedge nub_clkn);
        idle_bus();
        total++; if (mem_valid !== 1'b1 || mem_addr !== 32'hF900_0040) begin bad++; $display("FAIL first_accept: got valid=%b addr=%h want 1 f9000040", mem_valid, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h0;
        @(negedge nub_clkn);
        mem_ready = 1'b0;
        @(negedge nub_clkn);
    endtask

    task automatic test_read();
        int a0;
        a0 = ack_cnt;
        drive_start(32'hF900_0010, 1'b1, 1'b1);
        @(negedge nub_clkn);
        idle_bus();
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL rd_valid: got %b want 1", mem_valid); end
        total++; if (mem_addr !== 32'hF900_0010) begin bad++; $display("FAIL rd_addr: got %h want f9000010", mem_addr); end
        total++; if (mem_write !== 1'b0 || slv_ackcyn !== 1'b1) begin bad++; $display("FAIL rd_wait: got write=%b ackcyn=%b want 0 1", mem_write, slv_ackcyn); end
        @(negedge nub_clkn);
        @(negedge nub_clkn);
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge nub_clkn);
        mem_ready = 1'b0; mem_rdata = 32'h0;
        total++; if (slv_ackcyn !== 1'b0 || slv_errorn !== 2'b11) begin bad++; $display("FAIL rd_ack: got ackcyn=%b errorn=%b want 0 11", slv_ackcyn, slv_errorn); end
        total++; if (slv_adoe !== 1'b1) begin bad++; $display("FAIL rd_adoe: got %b want 1", slv_adoe); end
        total++; if (slv_rdatan !== 32'h2152_4110) begin bad++; $display("FAIL rd_rdatan: got %h want 21524110", slv_rdatan); end
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_ack: got %b want 0", mem_valid); end
        @(negedge nub_clkn);
        total++; if (slv_ackcyn !== 1'b1 || slv_adoe !== 1'b0) begin bad++; $display("FAIL rd_after: got ackcyn=%b adoe=%b want 1 0", slv_ackcyn, slv_adoe); end
        total++; if (ack_cnt - a0 != 1) begin bad++; $display("FAIL rd_ack_count: got %0d want 1", ack_cnt - a0); end
    endtask

    task automatic test_write();
        int a0;
        a0 = ack_cnt;
        drive_start(32'hF900_0002, 1'b0, 1'b0);
        @(negedge nub_clkn);
        nub_startn = 1'b1; nub_tm1n = 1'b1; nub_tm0n = 1'b1; nub_adn = ~32'h0000_00AB;
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL wr_wdata_valid: got %b want 0", mem_valid); end
        total++; if (mem_wstrb !== 4'b0100) begin bad++; $display("FAIL wr_wstrb: got %b want 0100", mem_wstrb); end
        total++; if (mem_write !== 1'b1 || mem_addr !== 32'hF900_0002) begin bad++; $display("FAIL wr_addr: got write=%b addr=%h want 1 f9000002", mem_write, mem_addr); end
        @(negedge nub_clkn);
        idle_bus();
        total++; if (mem_valid !== 1'b1 || mem_wdata !== 32'h0000_00AB) begin bad++; $display("FAIL wr_wdata: got valid=%b wdata=%h want 1 000000ab", mem_valid, mem_wdata); end
        mem_ready = 1'b1;
        @(negedge nub_clkn);
        mem_ready = 1'b0;
        total++; if (slv_ackcyn !== 1'b0 || slv_errorn !== 2'b11 || slv_adoe !== 1'b0) begin bad++; $display("FAIL wr_ack: got ackcyn=%b errorn=%b adoe=%b want 0 11 0", slv_ackcyn, slv_errorn, slv_adoe); end
        @(negedge nub_clkn);
        total++; if (ack_cnt - a0 != 1) begin bad++; $display("FAIL wr_ack_count: got %0d want 1", ack_cnt - a0); end
    endtask

    task automatic test_timeout();
        int bad_wait;
        bad_wait = 0;
        drive_start(32'hF900_0100, 1'b1, 1'b1);
        @(negedge nub_clkn);
        idle_bus();
        repeat (TMO) begin
            if (mem_valid !== 1'b1 || slv_ackcyn !== 1'b1) bad_wait++;
            @(negedge nub_clkn);
        end
        total++; if (bad_wait != 0) begin bad++; $display("FAIL tmo_wait: got %0d bad wait cycles want 0", bad_wait); end
        total++; if (slv_ackcyn !== 1'b0 || slv_errorn !== 2'b01 || slv_adoe !== 1'b0) begin bad++; $display("FAIL tmo_ack: got ackcyn=%b errorn=%b adoe=%b want 0 01 0", slv_ackcyn, slv_errorn, slv_adoe); end
        @(negedge nub_clkn);
    endtask

    task automatic test_decode();
        int a0;
        a0 = ack_cnt;
        valid_seen = 0;
        drive_start(32'hFA00_0010, 1'b1, 1'b1);
        @(negedge nub_clkn);
        drive_start(32'hF900_0010, 1'b1, 1'b1);
        nub_ackn = 1'b0;
        @(negedge nub_clkn);
        drive_start(32'hE900_0010, 1'b0, 1'b1);
        @(negedge nub_clkn);
        idle_bus();
        repeat (3) @(negedge nub_clkn);
        total++; if (valid_seen !== 1'b0) begin bad++; $display("FAIL dec_valid: got %b want 0", valid_seen); end
        total++; if (ack_cnt - a0 != 0) begin bad++; $display("FAIL dec_ack: got %0d want 0", ack_cnt - a0); end
    endtask

    task automatic test_reset_mid();
        int a0;
        a0 = ack_cnt;
        drive_start(32'hF900_0010, 1'b1, 1'b1);
        @(negedge nub_clkn);
        idle_bus();
        @(negedge nub_clkn);
        #2 nub_reset = 1'b1;
        #1;
        total++; if (mem_valid !== 1'b0 || slv_ackcyn !== 1'b1) begin bad++; $display("FAIL arst_ctl: got valid=%b ackcyn=%b want 0 1", mem_valid, slv_ackcyn); end
        total++; if (mem_addr !== 32'h0 || mem_wstrb !== 4'h0 || slv_rdatan !== 32'hFFFF_FFFF) begin bad++; $display("FAIL arst_data: got addr=%h wstrb=%b rdatan=%h", mem_addr, mem_wstrb, slv_rdatan); end
        @(negedge nub_clkn);
        nub_reset = 1'b0;
        drive_start(32'hF900_0020, 1'b1, 1'b1);
        @(negedge nub_clkn);
        idle_bus();
        total++; if (mem_valid !== 1'b1 || mem_addr !== 32'hF900_0020) begin bad++; $display("FAIL arst_next: got valid=%b addr=%h want 1 f9000020", mem_valid, mem_addr); end
        mem_ready = 1'b1; mem_rdata = 32'h0F0F_0F0F;
        @(negedge nub_clkn);
        mem_ready = 1'b0;
        total++; if (slv_ackcyn !== 1'b0 || slv_rdatan !== 32'hF0F0_F0F0) begin bad++; $display("FAIL arst_next_ack: got ackcyn=%b rdatan=%h want 0 f0f0f0f0", slv_ackcyn, slv_rdatan); end
        @(negedge nub_clkn);
        total++; if (ack_cnt - a0 != 1) begin bad++; $display("FAIL arst_ack_count: got %0d want 1", ack_cnt - a0); end
    endtask

    task automatic test_err_at_timeout();
        drive_start(32'hF900_0200, 1'b1, 1'b1);
        @(negedge nub_clkn);
        idle_bus();
        repeat (TMO - 1) @(negedge nub_clkn);
        total++; if (slv_ackcyn !== 1'b1 || mem_valid !== 1'b1) begin bad++; $display("FAIL err_pre: got ackcyn=%b valid=%b want 1 1", slv_ackcyn, mem_valid); end
        mem_ready = 1'b1; mem_err = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge nub_clkn);
        mem_ready = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
        total++; if (slv_ackcyn !== 1'b0 || slv_errorn !== 2'b10) begin bad++; $display("FAIL err_status: got ackcyn=%b errorn=%b want 0 10", slv_ackcyn, slv_errorn); end
        total++; if (slv_adoe !== 1'b0 || slv_rdatan !== 32'hEDCB_A987) begin bad++; $display("FAIL err_data: got adoe=%b rdatan=%h want 0 edcba987", slv_adoe, slv_rdatan); end
        @(negedge nub_clkn);
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = ack_cnt;
        drive_start(32'hF900_0030, 1'b1, 1'b1);
        @(negedge nub_clkn);
        idle_bus();
        mem_ready = 1'b1; mem_rdata = 32'hAAAA_5555;
        @(negedge nub_clkn);
        mem_ready = 1'b0;
        // START during the ACK cycle must be dropped.
        drive_start(32'hF900_0034, 1'b1, 1'b1);
        @(negedge nub_clkn);
        idle_bus();
        valid_seen = 0;
        repeat (2) @(negedge nub_clkn);
        total++; if (valid_seen !== 1'b0 || mem_addr !== 32'hF900_0030) begin bad++; $display("FAIL b2b_drop: got seen=%b addr=%h want 0 f9000030", valid_seen, mem_addr); end
        drive_start(32'hF900_0038, 1'b1, 1'b1);
        @(negedge nub_clkn);
        idle_bus();
        total++; if (mem_valid !== 1'b1 || mem_addr !== 32'hF900_0038) begin bad++; $display("FAIL b2b_next: got valid=%b addr=%h want 1 f9000038", mem_valid, mem_addr); end
        mem_ready = 1'b1;
        @(negedge nub_clkn);
        mem_ready = 1'b0;
        @(negedge nub_clkn);
        total++; if (ack_cnt - a0 != 2) begin bad++; $display("FAIL b2b_ack_count: got %0d want 2", ack_cnt - a0); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_decode();
        test_reset_mid();
        test_err_at_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
